// File: rtl/sprite_compositor_if.sv
// Pixel/sprite bus between the game-state/VGA timing side and the sprite compositor.
interface sprite_compositor_if #(
    parameter int unsigned NumSprites = 5
);
    logic                       frame_start;
    logic                       bright;
    logic [9:0]                 h_count;
    logic [9:0]                 v_count;
    logic [2:0]                 block_type;
    logic [20*NumSprites-1:0]   sprite_pos;
    logic [12*NumSprites-1:0]   sprite_size;
    logic [12*NumSprites-1:0]   sprite_rgb;
    logic [NumSprites-1:0]      sprite_enable;
    logic [NumSprites-1:0]      sprite_flash;
    logic [11:0]                rgb;
    logic [7:0]                 frame_count;

    modport master (
        output frame_start, bright, h_count, v_count, block_type,
        output sprite_pos, sprite_size, sprite_rgb, sprite_enable, sprite_flash,
        input  rgb, frame_count
    );

    modport slave (
        input  frame_start, bright, h_count, v_count, block_type,
        input  sprite_pos, sprite_size, sprite_rgb, sprite_enable, sprite_flash,
        output rgb, frame_count
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage sprite-over-tile pixel compositor with per-frame shadowed sprite state.
// Optional hit-flash blink timers are built when SPRITE_COMPOSITOR_FLASH_EN is defined.
module sprite_compositor #(
    parameter int unsigned NumSprites  = 5,
    parameter int unsigned FlashFrames = 60,
    parameter int unsigned BlinkShift  = 2,
    parameter logic [11:0] BgRgb       = 12'hFFF,
    parameter logic [11:0] FgRgb       = 12'h00F,
    parameter logic [11:0] SlabRgb     = 12'h0F0,
    parameter logic [11:0] DoorRgb     = 12'h630
) (
    input logic                clk_i,
    input logic                reset_i,
    sprite_compositor_if.slave bus_io
);

    logic [20*NumSprites-1:0] pos_q;
    logic [12*NumSprites-1:0] size_q;
    logic [12*NumSprites-1:0] col_q;
    logic [NumSprites-1:0]    en_q;
    logic [7:0]               frame_cnt_q;
    logic [NumSprites-1:0]    hidden;
    logic [NumSprites-1:0]    hit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pos_q       <= '0;
            size_q      <= '0;
            col_q       <= '0;
            en_q        <= '0;
            frame_cnt_q <= '0;
        end else if (bus_io.frame_start) begin
            pos_q       <= bus_io.sprite_pos;
            size_q      <= bus_io.sprite_size;
            col_q       <= bus_io.sprite_rgb;
            en_q        <= bus_io.sprite_enable;
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign bus_io.frame_count = frame_cnt_q;

`ifdef SPRITE_COMPOSITOR_FLASH_EN
    localparam int unsigned FlashW = $clog2(FlashFrames + 1);

    logic [NumSprites-1:0][FlashW-1:0] flash_q, flash_d;

    // A new request outranks the per-frame decrement.
    always_comb begin
        flash_d = flash_q;
        hidden  = '0;
        for (int i = 0; i < int'(NumSprites); i++) begin
            if (bus_io.sprite_flash[i]) begin
                flash_d[i] = FlashW'(FlashFrames);
            end else if (bus_io.frame_start && (flash_q[i] != '0)) begin
                flash_d[i] = flash_q[i] - FlashW'(1);
            end
            hidden[i] = (flash_q[i] != '0) && frame_cnt_q[BlinkShift];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flash_q <= '0;
        end else begin
            flash_q <= flash_d;
        end
    end
`else
    logic unused_flash;
    assign unused_flash = ^{bus_io.sprite_flash, 8'(BlinkShift), 8'(FlashFrames)};
    assign hidden       = '0;
`endif

    // Bounds are 11 bits wide so a sprite past column/row 1023 clips instead of wrapping.
    for (genvar g = 0; g < NumSprites; g++) begin : g_hit
        logic [10:0] x_lo, y_lo, x_hi, y_hi;
        logic [5:0]  w, h;
        assign x_lo = {1'b0, pos_q[20*g+10 +: 10]};
        assign y_lo = {1'b0, pos_q[20*g +: 10]};
        assign w    = size_q[12*g+6 +: 6];
        assign h    = size_q[12*g +: 6];
        assign x_hi = x_lo + 11'(w);
        assign y_hi = y_lo + 11'(h);
        assign hit[g] = en_q[g] && !hidden[g] && (w != '0) && (h != '0) &&
                        ({1'b0, bus_io.h_count} >= x_lo) && ({1'b0, bus_io.h_count} < x_hi) &&
                        ({1'b0, bus_io.v_count} >= y_lo) && ({1'b0, bus_io.v_count} < y_hi);
    end

    logic [11:0] spr_rgb;
    always_comb begin
        spr_rgb = '0;
        for (int i = int'(NumSprites) - 1; i >= 0; i--) begin
            if (hit[i]) spr_rgb = col_q[12*i +: 12];
        end
    end

    logic [4:0]  v_off;
    logic        tile_hit;
    logic [11:0] tile_rgb;
    assign v_off = bus_io.v_count[4:0] - 5'd3;  // low bits of (v_count - 35)

    always_comb begin
        tile_hit = 1'b0;
        tile_rgb = '0;
        case (bus_io.block_type)
            3'd1: begin
                tile_hit = 1'b1;
                tile_rgb = FgRgb;
            end
            3'd2: begin
                tile_hit = (v_off <= 5'd15);
                tile_rgb = SlabRgb;
            end
            3'd3: begin
                tile_hit = 1'b1;
                tile_rgb = DoorRgb;
            end
            default: ;
        endcase
    end

    // Stage 1 also captures the winning sprite colour so a frame_start latch one
    // cycle later cannot recolour a pixel already in flight.
    logic [NumSprites-1:0] hit_s1_q;
    logic [11:0]           spr_rgb_s1_q;
    logic                  tile_hit_s1_q;
    logic [11:0]           tile_rgb_s1_q;
    logic                  bright_s1_q;
    logic [11:0]           rgb_q, rgb_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_s1_q      <= '0;
            spr_rgb_s1_q  <= '0;
            tile_hit_s1_q <= 1'b0;
            tile_rgb_s1_q <= '0;
            bright_s1_q   <= 1'b0;
        end else begin
            hit_s1_q      <= hit;
            spr_rgb_s1_q  <= spr_rgb;
            tile_hit_s1_q <= tile_hit;
            tile_rgb_s1_q <= tile_rgb;
            bright_s1_q   <= bus_io.bright;
        end
    end

    always_comb begin
        rgb_d = BgRgb;
        if (!bright_s1_q) begin
            rgb_d = '0;
        end else if (|hit_s1_q) begin
            rgb_d = spr_rgb_s1_q;
        end else if (tile_hit_s1_q) begin
            rgb_d = tile_rgb_s1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus_io.rgb = rgb_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed scenarios plus random pixels
// checked against a frame-level behavioural model.
module tb_sprite_compositor;
    localparam int NS = 5;
    localparam int FF = 4;
    localparam int BS = 0;
    localparam logic [11:0] BG = 12'hFFF, FG = 12'h00F, SLAB = 12'h0F0, DOOR = 12'h630;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_compositor_if #(.NumSprites(NS)) bus ();

    sprite_compositor #(
        .NumSprites (NS),
        .FlashFrames(FF),
        .BlinkShift (BS),
        .BgRgb      (BG),
        .FgRgb      (FG),
        .SlabRgb    (SLAB),
        .DoorRgb    (DOOR)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus)
    );

    // Stimulus state
    int px = 0, py = 0;
    bit br = 0, fs = 0;
    bit [2:0] bt = 0;
    int sx[NS], sy[NS], sw[NS], sh[NS];
    bit [11:0] sc[NS];
    bit se[NS], sf[NS];

    // Reference model state
    int ax[NS], ay[NS], aw[NS], ah[NS];
    bit [11:0] ac[NS];
    bit ae[NS];
    int fl[NS];
    int fc = 0;

    typedef struct {
        int        due;
        bit [11:0] val;
    } exp_t;
    exp_t rgb_exp[$];
    exp_t fc_exp[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit [11:0] model_pixel();
        if (!br) return 12'h000;
        for (int i = 0; i < NS; i++) begin
            bit hid;
            hid = 0;
`ifdef SPRITE_COMPOSITOR_FLASH_EN
            hid = (fl[i] != 0) && (((fc >> BS) & 1) == 1);
`endif
            if (ae[i] && aw[i] > 0 && ah[i] > 0 && !hid &&
                px >= ax[i] && px <= ax[i] + aw[i] - 1 &&
                py >= ay[i] && py <= ay[i] + ah[i] - 1)
                return ac[i];
        end
        case (bt)
            3'd1: return FG;
            3'd2: if (((py - 35) & 31) <= 15) return SLAB;
            3'd3: return DOOR;
            default: ;
        endcase
        return BG;
    endfunction

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                ax[i] = 0; ay[i] = 0; aw[i] = 0; ah[i] = 0; ac[i] = 0; ae[i] = 0; fl[i] = 0;
            end
            fc = 0;
        end else begin
`ifdef SPRITE_COMPOSITOR_FLASH_EN
            for (int i = 0; i < NS; i++) begin
                if (sf[i]) fl[i] = FF;
                else if (fs && fl[i] > 0) fl[i] = fl[i] - 1;
            end
`endif
            if (fs) begin
                for (int i = 0; i < NS; i++) begin
                    ax[i] = sx[i]; ay[i] = sy[i]; aw[i] = sw[i]; ah[i] = sh[i];
                    ac[i] = sc[i]; ae[i] = se[i];
                end
                fc = (fc + 1) % 256;
            end
        end
    endtask

    // Drive one pixel, record its expected results, advance the model and the clock.
    task automatic step();
        logic [20*NS-1:0] pos;
        logic [12*NS-1:0] sz, col;
        logic [NS-1:0] en, fv;
        exp_t e;
        for (int i = 0; i < NS; i++) begin
            pos[20*i +: 20] = {10'(sx[i]), 10'(sy[i])};
            sz[12*i +: 12]  = {6'(sw[i]), 6'(sh[i])};
            col[12*i +: 12] = sc[i];
            en[i] = se[i];
            fv[i] = sf[i];
        end
        bus.frame_start   = fs;
        bus.bright        = br;
        bus.h_count       = 10'(px);
        bus.v_count       = 10'(py);
        bus.block_type    = bt;
        bus.sprite_pos    = pos;
        bus.sprite_size   = sz;
        bus.sprite_rgb    = col;
        bus.sprite_enable = en;
        bus.sprite_flash  = fv;
        if (reset) begin
            // The pixel one cycle ahead is flushed out of stage 1 by this reset.
            if (rgb_exp.size() > 0) begin
                exp_t last;
                last = rgb_exp.pop_back();
                last.val = 12'h000;
                rgb_exp.push_back(last);
            end
            e.val = 12'h000;
        end else begin
            e.val = model_pixel();
        end
        e.due = cyc + 2;
        rgb_exp.push_back(e);
        e.due = cyc;
        e.val = 12'(fc);
        fc_exp.push_back(e);
        model_update();
        fs = 0;
        for (int i = 0; i < NS; i++) sf[i] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                           input bit [11:0] c, input bit en);
        sx[i] = x; sy[i] = y; sw[i] = w; sh[i] = h; sc[i] = c; se[i] = en;
    endtask

    task automatic sweep(input int x0, input int x1, input int y);
        py = y;
        for (int x = x0; x <= x1; x++) begin
            px = x;
            step();
        end
    endtask

    task automatic frame();
        fs = 1;
        step();
    endtask

    // Monitor: pops whatever is due this cycle and compares with the DUT outputs.
    exp_t me;
    always @(negedge clk) begin
        while (fc_exp.size() > 0 && fc_exp[0].due <= cyc) begin
            me = fc_exp.pop_front();
            checks++;
            if (me.due != cyc || bus.frame_count !== me.val[7:0]) begin
                failures++;
                $display("FAIL frame_count cyc=%0d due=%0d got=%0d exp=%0d",
                         cyc, me.due, bus.frame_count, me.val[7:0]);
            end
        end
        while (rgb_exp.size() > 0 && rgb_exp[0].due <= cyc) begin
            me = rgb_exp.pop_front();
            checks++;
            if (me.due != cyc || bus.rgb !== me.val) begin
                failures++;
                $display("FAIL rgb cyc=%0d due=%0d got=%h exp=%h", cyc, me.due, bus.rgb, me.val);
            end
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            set_spr(i, 0, 0, 0, 0, 12'h000, 0);
            sf[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        step(); step();
        reset = 0;
        br = 1;
        // Latch and coordinate sweep
        set_spr(0, 100, 200, 32, 32, 12'hF00, 1);
        sweep(95, 96, 200);
        frame();
        sweep(95, 140, 200);
        sweep(95, 140, 231);
        sweep(95, 140, 232);
        sweep(98, 102, 199);
        // Priority over tiles and between channels
        set_spr(0, 40, 40, 16, 16, 12'hF00, 1);
        set_spr(3, 45, 45, 16, 16, 12'h0AB, 1);
        bt = 1;
        frame();
        sweep(38, 62, 50);
        se[0] = 0;
        frame();
        sweep(38, 62, 50);
        se[3] = 0;
        frame();
        sweep(48, 52, 50);
        bt = 0;
        // Tearing guard
        set_spr(2, 20, 20, 10, 10, 12'h123, 1);
        frame();
        sweep(15, 35, 25);
        sx[2] = 60;
        sweep(15, 75, 25);
        frame();
        sweep(15, 75, 25);
        // Flash and blink
        reset = 1; step(); reset = 0;
        set_spr(1, 10, 10, 8, 8, 12'h0C0, 1);
        sf[1] = 1;
        step();
        for (int f = 0; f < 8; f++) begin
            if (f == 2) sf[1] = 1;
            frame();
            sweep(8, 19, 12);
        end
        for (int f = 0; f < 7; f++) begin
            frame();
            sweep(9, 12, 12);
        end
        // Clipping, zero size, blanking
        set_spr(4, 1010, 300, 32, 8, 12'hABC, 1);
        set_spr(1, 500, 300, 0, 8, 12'h0C0, 1);
        frame();
        sweep(1000, 1023, 303);
        sweep(0, 12, 303);
        sweep(495, 505, 303);
        br = 0;
        sweep(1012, 1015, 303);
        br = 1;
        // Slab stripes
        bt = 2;
        for (int y = 30; y < 90; y++) begin
            px = 700; py = y; step();
        end
        bt = 0;
        // Reset mid-frame while drawing
        set_spr(0, 200, 100, 20, 20, 12'hE0E, 1);
        frame();
        sweep(195, 205, 105);
        reset = 1; step(); step(); reset = 0;
        sweep(206, 215, 105);
        frame();
        sweep(195, 225, 105);
        // Frame counter wrap
        for (int f = 0; f < 260; f++) begin
            frame();
            px = 0; py = 0; step();
        end
        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int k, x, y;
                k = $urandom_range(0, NS - 1);
                x = ($urandom_range(0, 9) == 0) ? $urandom_range(980, 1023) : $urandom_range(0, 120);
                y = ($urandom_range(0, 9) == 0) ? $urandom_range(980, 1023) : $urandom_range(0, 120);
                set_spr(k, x, y, $urandom_range(0, 40), $urandom_range(0, 40), 12'($urandom),
                        $urandom_range(0, 5) != 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                px = ($urandom_range(0, 1) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 15);
                py = ($urandom_range(0, 1) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 15);
            end else begin
                px = $urandom_range(0, 160);
                py = $urandom_range(0, 160);
            end
            bt = 3'($urandom_range(0, 7));
            br = $urandom_range(0, 9) != 0;
            fs = $urandom_range(0, 19) == 0;
            for (int i = 0; i < NS; i++) sf[i] = $urandom_range(0, 63) == 0;
            reset = $urandom_range(0, 699) == 0;
            step();
            reset = 0;
        end
        // Drain
        br = 0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (rgb_exp.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", rgb_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised per-pixel compositor replacing the fixed-object display controller: composites NUM_SPRITES rectangular, solid-colour sprites over the 3-bit tile layer (foreground, half slab, door) into a 12-bit RGB pixel. Sprite state is latched once per frame on frameStart, so the game logic can update positions mid-frame without tearing. Compositing is a 2-stage pipeline. Per-sprite hit-flash (blink) timers are driven by frame counting. It sits between the game-state modules and the VGA output, fed by the same hCount/vCount/bright timing.

## Interface
- NUM_SPRITES, 5: number of sprite channels (1..16); channel 0 has highest priority.
- FLASH_FRAMES, 60: frames a flash lasts after a flash request.
- BLINK_SHIFT, 2: frame-counter bit that gates visibility during a flash; the period is 2^(BLINK_SHIFT+1) frames.
- BG_RGB, 12'hFFF: colour when no sprite or tile hits.
- FG_RGB, 12'h00F; SLAB_RGB, 12'h0F0; DOOR_RGB, 12'h630: tile colours for block types 1, 2 and 3.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- frameStart  in  1  one-cycle pulse at the start of the frame; latches sprite state.
- bright  in  1  visible-area flag, aligned with hCount/vCount.
- hCount, vCount  in  10 each  current pixel coordinates.
- blockType  in  3  tile type at the current pixel, aligned with hCount/vCount.
- spritePos  in  20*NUM_SPRITES  per channel i, bits [20i+19:20i+10] = X and [20i+9:20i] = Y of the top-left corner.
- spriteSize  in  12*NUM_SPRITES  per channel, [12i+11:12i+6] = width and [12i+5:12i] = height. Each is 6 bits; 0 disables the channel.
- spriteRgb  in  12*NUM_SPRITES  per-channel colour.
- spriteEnable  in  NUM_SPRITES  per-channel visible flag.
- spriteFlash  in  NUM_SPRITES  per-channel one-cycle flash request.
- rgb  out  12  registered pixel colour.
- frameCount  out  8  frames since reset; wraps modulo 256.

## Operation
- **Shadow registers.** When frameStart is high, latch spritePos, spriteSize, spriteRgb and spriteEnable into the active registers. The active registers hold their values at all other times.
- **Hit test.** Channel i hits when all of the following hold:
  - X ≤ hCount ≤ X+W−1 and Y ≤ vCount ≤ Y+H−1;
  - W ≠ 0, H ≠ 0 and enable = 1;
  - the channel is not flash-hidden.
  - Compute the bounds in 11 bits. A sprite extending past coordinate 1023 is clipped, never wrapped.
- **Tile hit.**
  - Type 1: FG_RGB.
  - Type 2: SLAB_RGB, only when ((vCount−35) & 31) ≤ 15.
  - Type 3: DOOR_RGB.
  - Types 0 and 4..7: no hit.
- **Priority.** Output colour is chosen in this order:
  1. bright = 0 → 12'h000;
  2. the lowest-index hitting sprite;
  3. the tile colour;
  4. BG_RGB.
- **Flash.**
  - Each channel has a counter flashCnt[i] wide enough to hold FLASH_FRAMES.
  - spriteFlash[i] loads FLASH_FRAMES.
  - frameStart decrements any nonzero counter.
  - If a load and frameStart occur in the same cycle, the load wins.
  - The channel is flash-hidden while flashCnt[i] ≠ 0 and frameCount[BLINK_SHIFT] = 1.
  - A re-request during an active flash restarts the count.
- **Frame counter.** frameCount increments on each frameStart, 255 wraps to 0.
- **Reset.** Reset clears rgb, frameCount, all active shadow registers, all flash counters and all pipeline registers to 0. All sprites are therefore hidden until the first frameStart.

## Timing
- **Latency.** Pixel (hCount, vCount, bright, blockType) at cycle n → rgb valid at cycle n+2.
  - Stage 1 registers the per-channel hit vector, the tile colour/hit and bright.
  - Stage 2 registers the priority-selected rgb.
- **Shadow update.** Values latched by frameStart in cycle n are used for the pixel sampled in cycle n+1. The pixel presented in cycle n itself uses the old values.
- **Counter update.** frameCount and flashCnt update in the same edge as the latch. The new frameCount value applies from cycle n+1.
- **Reset mid-frame.** Reset takes effect at the next edge. rgb reads 0 for the reset cycle plus 2 cycles while the pipeline refills with zeros.
- Throughput is one pixel per clock. There is no stall and no backpressure.

## Configuration
- Macro: SPRITE_COMPOSITOR_FLASH_EN.
- **Defined:** flash counters and blink gating are built as specified.
- **Undefined:**
  - No flashCnt registers are built.
  - spriteFlash is ignored.
  - No sprite is ever flash-hidden.
  - frameCount remains present.

## Test plan
1. **Latch and coordinates.** Reset, then frameStart with ch0 at X=100, Y=200, W=32, H=32, rgb=12'hF00, enable=1. Sweep a line.
   - Expected: rgb = 12'hF00 exactly at hCount 100..131 and vCount 200..231.
   - Expected: each value appears 2 cycles after its pixel.
   - Expected: BG_RGB at hCount 99 and 132.
2. **Priority.** ch0 and ch3 overlap at (50,50) with blockType = 1.
   - Expected: ch0 colour at (50,50).
   - With ch0 disabled and a new frameStart: ch3 colour.
   - With both disabled: 12'h00F.
3. **Tearing guard.** Change spritePos mid-frame without a frameStart → rgb is unchanged. After the next frameStart → rgb reflects the new position.
4. **Flash.** With FLASH_FRAMES = 4 and BLINK_SHIFT = 0, pulse spriteFlash[1] from frameCount = 0.
   - Expected: ch1 hidden on frames with an odd frameCount while the counter is nonzero.
   - Expected: visible every frame once the counter reaches 0.
   - Expected: a pulse coincident with frameStart reloads the counter to 4.
   - With the macro undefined: ch1 is always visible.
5. **Clipping and edges.**
   - X = 1010, W = 32 → hits at hCount 1010..1023 only, with no hit at hCount 0..9.
   - W = 0 → never hits.
   - bright = 0 inside a sprite → 12'h000.
6. **Reset mid-frame.** Assert reset while a sprite is drawing.
   - Expected: rgb = 0 for 3 cycles, frameCount = 0.
   - Expected: sprite hidden until the next frameStart.
